// File: rtl/full_adder_chk_pkg.sv
// Shared definitions for the on-board full-adder checker.
// Holds the state encoding, vector bounds and the golden full-adder model.
package full_adder_chk_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] APPLY = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int         NUM_VECTORS = 8;
   localparam logic [2:0] LAST_VEC    = 3'd7;

   // Vector bit order is {a, b, cin}; the result is packed as {cout, sum}.
   function automatic logic [1:0] golden_model(input logic [2:0] vec);
      logic exp_sum;
      logic exp_cout;
      exp_sum  = vec[2] ^ vec[1] ^ vec[0];
      exp_cout = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
      return {exp_cout, exp_sum};
   endfunction

endpackage

// File: rtl/full_adder_golden.sv
// Combinational reference full adder.
// Takes a packed {a, b, cin} vector and returns the expected sum and carry.
module full_adder_golden
   import full_adder_chk_pkg::*;
(
   input  logic [2:0] vec_i,
   output logic       exp_sum_o,
   output logic       exp_cout_o
);

   always_comb begin
      {exp_cout_o, exp_sum_o} = golden_model(vec_i);
   end

endmodule

// File: rtl/full_adder_checker.sv
// Self-checking stimulus driver for an external combinational full adder.
// Walks all eight input vectors, samples the adder after a dwell window and reports the results.
module full_adder_checker
   import full_adder_chk_pkg::*;
#(
   parameter int DWELL_CYCLES = 15,
   parameter int ERR_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   output logic             cin_o,
   input  logic             sum_i,
   input  logic             cout_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_valid,
   output logic [2:0]       fail_vec
);

   localparam int               VEC_W      = $clog2(NUM_VECTORS);
   localparam int               DW_W       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;

   logic [1:0]       state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [DW_W-1:0]  dwell_q, dwell_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             fail_valid_q, fail_valid_d;
   logic [2:0]       fail_vec_q, fail_vec_d;
   logic             pass_q, pass_d;
   logic [2:0]       drv_q, drv_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic exp_sum;
   logic exp_cout;
   logic mismatch;

   full_adder_golden u_golden (
      .vec_i      (vec_q),
      .exp_sum_o  (exp_sum),
      .exp_cout_o (exp_cout)
   );

   assign mismatch = (sum_i != exp_sum) || (cout_i != exp_cout);

   always_comb begin
      state_d      = state_q;
      vec_d        = vec_q;
      dwell_d      = dwell_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;
      pass_d       = pass_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = APPLY;
               vec_d        = '0;
               dwell_d      = '0;
               err_d        = '0;
               fail_valid_d = 1'b0;
               fail_vec_d   = '0;
               pass_d       = 1'b0;
            end
         end
         APPLY: begin
            // The counter may wrap on the last APPLY cycle; CHECK reloads it anyway.
            dwell_d = dwell_q + 1'b1;
            if (dwell_q == DWELL_LAST) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (mismatch) begin
               if (err_q != ERR_MAX) begin
                  err_d = err_q + 1'b1;
               end
               if (!fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  fail_vec_d   = vec_q;
               end
            end
            if (vec_q == LAST_VEC) begin
               state_d = DONE;
               pass_d  = (err_d == '0);
            end else begin
               state_d = APPLY;
               vec_d   = vec_q + 1'b1;
               dwell_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they change on the same edge as the FSM.
      busy_d = (state_d == APPLY) || (state_d == CHECK);
      done_d = (state_d == DONE);
      drv_d  = busy_d ? vec_d : 3'b000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         vec_q        <= '0;
         dwell_q      <= '0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= '0;
         pass_q       <= 1'b0;
         drv_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vec_q        <= vec_d;
         dwell_q      <= dwell_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         fail_vec_q   <= fail_vec_d;
         pass_q       <= pass_d;
         drv_q        <= drv_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign a_o        = drv_q[2];
   assign b_o        = drv_q[1];
   assign cin_o      = drv_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fail_valid_q;
   assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_full_adder_checker.sv
// Directed bench for full_adder_checker with a configurable, optionally faulty or delayed adder model.
// A second checker instance with ERR_W=2 always sees an adder with an inverted carry.
module tb_full_adder_checker;

   localparam int D        = 15;
   localparam int RUN_LEN  = 8 * (D + 1);
   localparam int M_OK     = 0;
   localparam int M_SUM0   = 1;
   localparam int M_COUTINV = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;

   always #5 clk = ~clk;

   logic       a1, b1, c1, sum1, cout1, busy1, done1, pass1, fv1;
   logic [3:0] err1;
   logic [2:0] fvec1;
   logic       a2, b2, c2, sum2, cout2, busy2, done2, pass2, fv2;
   logic [1:0] err2;
   logic [2:0] fvec2;

   int mode = M_OK;
   int delay = 0;
   int checks = 0;
   int errors = 0;

   full_adder_checker #(.DWELL_CYCLES(D), .ERR_W(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a_o(a1), .b_o(b1), .cin_o(c1), .sum_i(sum1), .cout_i(cout1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fv1), .fail_vec(fvec1)
   );

   full_adder_checker #(.DWELL_CYCLES(D), .ERR_W(2)) dut_sat (
      .clk(clk), .rst(rst), .start(start),
      .a_o(a2), .b_o(b2), .cin_o(c2), .sum_i(sum2), .cout_i(cout2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_valid(fv2), .fail_vec(fvec2)
   );

   // Adder model for the main instance: optional input delay line plus fault injection.
   logic [2:0] pipe [0:31];
   logic [2:0] tap;
   logic [1:0] add1;
   logic [1:0] add2;

   always @(posedge clk) begin
      pipe[0] <= {a1, b1, c1};
      for (int i = 1; i < 32; i++) pipe[i] <= pipe[i-1];
   end

   always_comb begin
      tap   = (delay == 0) ? {a1, b1, c1} : pipe[delay-1];
      add1  = 2'(tap[2]) + 2'(tap[1]) + 2'(tap[0]);
      sum1  = add1[0];
      cout1 = add1[1];
      if (mode == M_SUM0) sum1 = 1'b0;
      if (mode == M_COUTINV) cout1 = ~add1[1];
      add2  = 2'(a2) + 2'(b2) + 2'(c2);
      sum2  = add2[0];
      cout2 = ~add2[1];
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] outs1();
      return {a1, b1, c1, busy1, done1, pass1, err1, fv1, fvec1};
   endfunction

   // Pulses start and follows the run; optional start re-pulse and mid-run reset.
   task automatic run(input string name, input int repulse_at, input int rst_at,
                      input bit trace, output int cycles);
      cycles = -1;
      @(negedge clk);
      start = 1'b1;
      for (int j = 0; j <= RUN_LEN + 20; j++) begin
         @(posedge clk);
         #1;
         if (j == 0) begin
            start = 1'b0;
            check_val({name, "_start_busy"}, busy1, 1);
            check_val({name, "_start_cleared"}, {done1, pass1, err1, fv1, fvec1}, 0);
         end
         if (j == repulse_at) start = 1'b1;
         if (j == repulse_at + 1) start = 1'b0;
         if (j == rst_at) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check_val({name, "_abort_outputs"}, outs1(), 0);
            cycles = -2;
            $display("run %s: reset at cycle %0d, outputs=%0h", name, j, outs1());
            return;
         end
         if (trace && j < RUN_LEN) begin
            check_val({name, "_trace_vec"}, {a1, b1, c1}, j / (D + 1));
            check_val({name, "_trace_busy"}, busy1, 1);
         end
         if (done1) begin
            cycles = j;
            break;
         end
      end
      $display("run %s: cycles=%0d done=%0d pass=%0d err=%0d fail_valid=%0d fail_vec=%0d",
               name, cycles, done1, pass1, err1, fv1, fvec1);
   endtask

   initial begin
      int cyc;

      repeat (3) @(posedge clk);
      #1;
      check_val("reset_outputs", outs1(), 0);
      check_val("reset_outputs_sat", {a2, b2, c2, busy2, done2, pass2, err2, fv2, fvec2}, 0);

      // Reset and start together: reset wins.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_beats_start", {busy1, a1, b1, c1}, 0);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      $display("reset released");

      // Correct adder: full trace, 128-cycle run, pass.
      mode = M_OK;
      run("good", -1, -1, 1'b1, cyc);
      check_val("good_cycles", cyc, RUN_LEN);
      check_val("good_result", {done1, pass1, err1, fv1}, {1'b1, 1'b1, 4'd0, 1'b0});
      check_val("good_drive_idle", {a1, b1, c1, busy1}, 0);
      repeat (5) @(posedge clk);
      #1;
      check_val("good_hold", {done1, pass1}, 2'b11);

      // Sum stuck at 0: vectors 1,2,4,7 fail.
      mode = M_SUM0;
      run("sum0", -1, -1, 1'b0, cyc);
      check_val("sum0_err", err1, 4);
      check_val("sum0_fail_vec", fvec1, 1);
      check_val("sum0_flags", {done1, fv1, pass1}, 3'b110);

      // Restart from a failing DONE: results clear on the start edge, then a clean pass.
      mode = M_OK;
      run("restart", -1, -1, 1'b0, cyc);
      check_val("restart_cycles", cyc, RUN_LEN);
      check_val("restart_pass", {pass1, err1, fv1}, {1'b1, 4'd0, 1'b0});

      // Inverted carry: all vectors fail; the 2-bit counter saturates at 3.
      mode = M_COUTINV;
      run("coutinv", -1, -1, 1'b0, cyc);
      check_val("coutinv_err", err1, 8);
      check_val("coutinv_fail_vec", {fv1, fvec1}, {1'b1, 3'd0});
      check_val("coutinv_pass", pass1, 0);
      check_val("sat_err", err2, 3);
      check_val("sat_flags", {done2, pass2, fv2, fvec2}, {1'b1, 1'b0, 1'b1, 3'd0});

      // Reset at cycle 50 aborts; next run is clean.
      mode = M_OK;
      run("abort", -1, 50, 1'b0, cyc);
      run("after_abort", -1, -1, 1'b0, cyc);
      check_val("after_abort_cycles", cyc, RUN_LEN);
      check_val("after_abort_pass", {pass1, err1}, {1'b1, 4'd0});

      // Start re-pulsed while busy is ignored.
      run("repulse", 30, -1, 1'b0, cyc);
      check_val("repulse_cycles", cyc, RUN_LEN);
      check_val("repulse_pass", pass1, 1);

      // Adder latency just inside and just outside the dwell window.
      delay = D - 1;
      run("delay_in", -1, -1, 1'b0, cyc);
      check_val("delay_in_pass", {pass1, err1}, {1'b1, 4'd0});
      delay = D + 1;
      run("delay_out", -1, -1, 1'b0, cyc);
      check_val("delay_out_err_nonzero", err1 != 0, 1);
      check_val("delay_out_fail_vec", {fv1, fvec1, pass1}, {1'b1, 3'd1, 1'b0});
      delay = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/full_adder_checker.md
Name: full_adder_checker

Overview:
- Synthesizable self-checking driver for the combinational `full_adder`.
- Walks all 8 input vectors, holds each for a settle window, then samples the DUT's `SUM`/`carry_out`.
- Compares each sample against a golden model and reports error count, first failing vector and pass/fail.
- Sits opposite the adder on the board/top level: drives its inputs and receives its outputs, replacing a manual testbench for on-FPGA lab checkout.

Parameters:
- DWELL_CYCLES, 15, cycles each vector is held before sampling; legal range >= 1.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level/pulse; sampled only in IDLE or DONE.
- a_o  output  1  drives DUT A.
- b_o  output  1  drives DUT B.
- cin_o  output  1  drives DUT carry_in.
- sum_i  input  1  from DUT SUM.
- cout_i  input  1  from DUT carry_out.
- busy  output  1  high in APPLY/CHECK.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 iff err_count==0.
- err_count  output  ERR_W  mismatching vectors, saturating.
- fail_valid  output  1  a mismatch has been captured this run.
- fail_vec  output  3  index of first mismatching vector.

Behaviour:
- Reset (rst=1 at clock edge): state IDLE, vec=0, dwell=0. All outputs 0: a_o, b_o, cin_o, busy, done, pass, err_count, fail_valid, fail_vec.
- Reset mid-run aborts the run; no partial results are retained.
- Vector mapping: index v[2:0] gives a_o=v[2], b_o=v[1], cin_o=v[0]. Run order is v=0..7 (000, 001, 010, ... 111).
- Golden model: exp_sum = a^b^cin; exp_cout = (a&b)|(a&cin)|(b&cin).
- States:
  - IDLE: start=1 -> APPLY, with vec=0, dwell=0, err_count=0, fail_valid=0, fail_vec=0, pass=0.
  - APPLY: drive vector vec. dwell increments every cycle. When dwell==DWELL_CYCLES-1 -> CHECK.
  - CHECK, one cycle: vector stays driven. Sample sum_i/cout_i and compare against the golden model.
    - On mismatch: err_count += 1, saturating at 2^ERR_W-1.
    - On mismatch with fail_valid==0: fail_vec=vec, fail_valid=1.
    - If vec==7 -> DONE. Else vec+=1, dwell=0 -> APPLY.
  - DONE: done=1, pass=(err_count==0); drive outputs return to 0. Results hold until reset or restart. start=1 -> APPLY with results cleared, same as from IDLE.
- Timing:
  - Each vector occupies DWELL_CYCLES+1 cycles.
  - busy rises on the edge that samples start.
  - done rises exactly 8*(DWELL_CYCLES+1) edges later: 128 with defaults.
  - The DUT sees each vector for DWELL_CYCLES full cycles before sampling.
- start while busy is ignored; it neither restarts nor extends the run.
- Simultaneous rst and start: rst wins.
- The mismatch that pushes err_count to saturation is still counted. Further mismatches leave err_count at max; fail_vec is unaffected.
- pass is registered and updates on the CHECK(vec=7) -> DONE transition, together with done.
- Inputs sum_i/cout_i are used only in the CHECK state.

Decomposition:
- Package full_adder_chk_pkg:
  - state encoding constants IDLE/APPLY/CHECK/DONE (2 bits);
  - NUM_VECTORS=8, LAST_VEC=3'd7;
  - golden-model function returning {exp_cout, exp_sum} from a 3-bit vector.
- One natural sub-module: full_adder_golden (combinational, 3-bit vector in, exp_sum/exp_cout out). It lets the same model drive bench scoreboards.
- Remaining FSM, counters and capture logic in a single always block plus output registers.

Test Plan:
- Correct adder model connected, start pulse -> busy for 128 cycles; done=1, pass=1, err_count=0, fail_valid=0. a_o/b_o/cin_o trace 000..111, each held 16 cycles.
- sum_i stuck at 0 -> mismatches at v=1,2,4,7; err_count=4, fail_vec=1, fail_valid=1, pass=0.
- cout_i inverted, ERR_W=2 -> all 8 vectors fail; err_count saturates at 3, fail_vec=0, pass=0.
- rst asserted at cycle 50 of a run -> next edge all outputs 0, state IDLE. Subsequent start gives a clean full run with pass=1.
- start re-pulsed at cycle 30 of a run -> ignored, done still at cycle 128. start in DONE after a failing run -> err_count/fail_valid/pass clear on that edge and the run repeats.
- DUT model with output delay DWELL_CYCLES-1 cycles -> pass=1. With delay DWELL_CYCLES+1 cycles -> err_count>0, confirming the sample point.
